// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with push/pop handshake.
//
// Parameters
//   DWIDTH    - data word width
//   AWIDTH    - address width, DEPTH = 2**AWIDTH
//   AF_THRESH - f_almost_full when f_counter >= AF_THRESH (1..DEPTH)
//   AE_THRESH - f_almost_empty when f_counter <= AE_THRESH (0..DEPTH-1)
//   FWFT      - 0: registered read data, 1: first-word-fall-through
//
// Ports
//   clk            - clock, rising edge
//   rst            - asynchronous reset, active low
//   f_in           - write data
//   wr_en / rd_en  - push / pop requests
//   err_clr        - synchronous clear of the sticky error flags
//   f_out          - read data
//   f_empty, f_full, f_almost_full, f_almost_empty - occupancy flags
//   f_counter      - occupancy, 0..DEPTH
//   f_overflow     - sticky: a push was dropped
//   f_underflow    - sticky: a pop was dropped
module fifo_param #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] f_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] f_out,
    output logic              f_empty,
    output logic              f_full,
    output logic              f_almost_full,
    output logic              f_almost_empty,
    output logic [AWIDTH:0]   f_counter,
    output logic              f_overflow,
    output logic              f_underflow
);

    localparam int              DEPTH     = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_CNT    = (AWIDTH + 1)'(AF_THRESH);
    localparam logic [AWIDTH:0] AE_CNT    = (AWIDTH + 1)'(AE_THRESH);
    localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic wr_ok;
    logic rd_ok;

    // Flags decode only from the registered counter, so no request input
    // has a combinational path to any flag.
    assign f_counter      = count_q;
    assign f_empty        = (count_q == '0);
    assign f_full         = (count_q == DEPTH_CNT);
    assign f_almost_full  = (count_q >= AF_CNT);
    assign f_almost_empty = (count_q <= AE_CNT);
    assign f_overflow     = ovf_q;
    assign f_underflow    = udf_q;

    // A read never rescues an empty FIFO, but a simultaneous read lets a
    // write through when full (the freed slot is the one being written).
    assign rd_ok = rd_en & ~f_empty;
    assign wr_ok = wr_en & (~f_full | rd_ok);

    // FWFT exposes the head slot directly; standard mode uses the register.
    assign f_out = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem[rd_ptr_q];
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end

        // Clear first so that a new error in the same cycle wins.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en && !wr_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_en && !rd_ok) begin
            udf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; its
    // contents are only ever observed through slots the pointers mark valid,
    // and keeping it reset-free lets it map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= f_in;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] f_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;

    // Standard-mode instance outputs
    logic [DW-1:0] s_out;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
    logic [AW:0]   s_cnt;
    // FWFT instance outputs
    logic [DW-1:0] w_out;
    logic          w_empty, w_full, w_af, w_ae, w_ovf, w_udf;
    logic [AW:0]   w_cnt;

    always #5 clk = ~clk;

    fifo_param #(.DWIDTH(DW), .AWIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .f_in(f_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
        .f_out(s_out), .f_empty(s_empty), .f_full(s_full), .f_almost_full(s_af),
        .f_almost_empty(s_ae), .f_counter(s_cnt), .f_overflow(s_ovf), .f_underflow(s_udf)
    );

    fifo_param #(.DWIDTH(DW), .AWIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .f_in(f_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
        .f_out(w_out), .f_empty(w_empty), .f_full(w_full), .f_almost_full(w_af),
        .f_almost_empty(w_ae), .f_counter(w_cnt), .f_overflow(w_ovf), .f_underflow(w_udf)
    );

    typedef struct {
        string         name;
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        int            exp_cnt;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];          // scoreboard of words in flight
    logic [DW-1:0] exp_dout = '0;  // expected standard-mode f_out
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic rd, input logic clr,
                                input logic [DW-1:0] din, input int cnt, input logic ovf,
                                input logic udf);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    task automatic check_flags(input string tag, input int cnt, input logic ovf, input logic udf);
        check({tag, ".s_cnt"},   32'(s_cnt),   32'(cnt));
        check({tag, ".s_empty"}, 32'(s_empty), 32'(cnt == 0));
        check({tag, ".s_full"},  32'(s_full),  32'(cnt == DEPTH));
        check({tag, ".s_af"},    32'(s_af),    32'(cnt >= AF));
        check({tag, ".s_ae"},    32'(s_ae),    32'(cnt <= AE));
        check({tag, ".s_ovf"},   32'(s_ovf),   32'(ovf));
        check({tag, ".s_udf"},   32'(s_udf),   32'(udf));
        check({tag, ".w_cnt"},   32'(w_cnt),   32'(cnt));
        check({tag, ".w_empty"}, 32'(w_empty), 32'(cnt == 0));
        check({tag, ".w_full"},  32'(w_full),  32'(cnt == DEPTH));
        check({tag, ".w_af"},    32'(w_af),    32'(cnt >= AF));
        check({tag, ".w_ae"},    32'(w_ae),    32'(cnt <= AE));
        check({tag, ".w_ovf"},   32'(w_ovf),   32'(ovf));
        check({tag, ".w_udf"},   32'(w_udf),   32'(udf));
    endtask

    // Drive one vector at a falling edge, let one rising edge happen, update
    // the scoreboard, and compare at the next falling edge.
    task automatic apply(input vec_t v);
        logic rd_acc;
        logic wr_acc;
        rd_acc  = v.rd && (sb.size() != 0);
        wr_acc  = v.wr && ((sb.size() != DEPTH) || rd_acc);
        wr_en   = v.wr;
        rd_en   = v.rd;
        err_clr = v.clr;
        f_in    = v.din;
        @(posedge clk);
        if (rd_acc) exp_dout = sb.pop_front();
        if (wr_acc) sb.push_back(v.din);
        @(negedge clk);
        check_flags(v.name, v.exp_cnt, v.exp_ovf, v.exp_udf);
        check({v.name, ".s_out"}, 32'(s_out), 32'(exp_dout));
        if (sb.size() != 0) check({v.name, ".w_out"}, 32'(w_out), 32'(sb[0]));
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        // ---------------- vector table ----------------
        vecs.push_back(mk("push1", 1, 0, 0, 8'd1, 1, 0, 0));
        vecs.push_back(mk("push2", 1, 0, 0, 8'd2, 2, 0, 0));
        vecs.push_back(mk("push3", 1, 0, 0, 8'd3, 3, 0, 0));
        vecs.push_back(mk("pop1",  0, 1, 0, 8'd0, 2, 0, 0));
        vecs.push_back(mk("pop2",  0, 1, 0, 8'd0, 1, 0, 0));
        vecs.push_back(mk("pop3",  0, 1, 0, 8'd0, 0, 0, 0));
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mk($sformatf("fill%0d", i), 1, 0, 0, 8'(10 * i), i, 0, 0));
        vecs.push_back(mk("push90_full", 1, 0, 0, 8'd90, 8, 1, 0));
        vecs.push_back(mk("both99_full", 1, 1, 0, 8'd99, 8, 1, 0));
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mk($sformatf("drain%0d", i), 0, 1, 0, 8'd0, DEPTH - i, 1, 0));
        vecs.push_back(mk("clr_ovf",     0, 0, 1, 8'd0, 0, 0, 0));
        vecs.push_back(mk("rd_empty_w7", 1, 1, 0, 8'd7, 1, 0, 1));
        vecs.push_back(mk("clr_udf",     0, 0, 1, 8'd0, 1, 0, 0));
        vecs.push_back(mk("pop7",        0, 1, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk("clr_vs_udf",  0, 1, 1, 8'd0, 0, 0, 1));
        vecs.push_back(mk("clr_udf2",    0, 0, 1, 8'd0, 0, 0, 0));
        vecs.push_back(mk("push55",      1, 0, 0, 8'h55, 1, 0, 0));
        vecs.push_back(mk("pop55",       0, 1, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk("pushAA",      1, 0, 0, 8'hAA, 1, 0, 0));
        vecs.push_back(mk("popAA",       0, 1, 0, 8'd0, 0, 0, 0));

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_flags("reset", 0, 0, 0);
        check("reset.s_out", 32'(s_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- asynchronous reset mid-stream ----------------
        apply(mk("pre_udf", 0, 1, 0, 8'd0, 0, 0, 1));
        for (int i = 1; i <= 5; i++)
            apply(mk($sformatf("pre_push%0d", i), 1, 0, 0, 8'(8'hC0 + i), i, 0, 1));
        #2;
        rst = 1'b0;
        #1;  // still well before the next rising edge
        check_flags("async_rst", 0, 0, 0);
        check("async_rst.s_out", 32'(s_out), 32'd0);
        sb.delete();
        exp_dout = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply(mk("post_push3C", 1, 0, 0, 8'h3C, 1, 0, 0));
        apply(mk("post_pop3C",  0, 1, 0, 8'd0,  0, 0, 0));
        check("post_pop3C.value", 32'(s_out), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO. It is the next generation of the team's 8-deep byte FIFO and keeps the same port naming and push/pop handshake. New in this generation: configurable data width and depth, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic in a single clock domain.

## Interface
- DWIDTH, 8 — data word width in bits.
- AWIDTH, 3 — address width; DEPTH = 2**AWIDTH entries (default 8).
- AF_THRESH, 6 — f_almost_full asserts when f_counter >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2 — f_almost_empty asserts when f_counter <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0 — 0 selects standard registered-read mode; 1 selects first-word-fall-through mode.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-low reset.
- f_in  in  DWIDTH  — write data, sampled on a clk edge when a write is accepted.
- wr_en  in  1  — push request.
- rd_en  in  1  — pop request.
- err_clr  in  1  — synchronous clear of f_overflow and f_underflow.
- f_out  out  DWIDTH  — read data.
- f_empty  out  1  — high when f_counter == 0.
- f_full  out  1  — high when f_counter == DEPTH.
- f_almost_full  out  1  — high when f_counter >= AF_THRESH.
- f_almost_empty  out  1  — high when f_counter <= AE_THRESH.
- f_counter  out  AWIDTH+1  — current occupancy, 0..DEPTH.
- f_overflow  out  1  — sticky flag: a write was dropped.
- f_underflow  out  1  — sticky flag: a read was dropped.

## Operation
- Storage is a DEPTH x DWIDTH register array.
- Pointers:
  - wr_ptr and rd_ptr are AWIDTH bits wide and wrap naturally from DEPTH-1 to 0.
  - The occupancy counter is AWIDTH+1 bits.
  - All status flags decode from the registered counter, so they are glitch-free.
- Write accepted (wr_ok) = wr_en & (!f_full | rd_ok).
  - The write stores f_in at mem[wr_ptr] and increments wr_ptr.
  - When full, a write is accepted only if a read is accepted in the same cycle.
- Read accepted (rd_ok) = rd_en & !f_empty.
  - A read on an empty FIFO is always rejected, even if a write occurs in the same cycle.
- Counter update per edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- Standard mode (FWFT=0):
  - f_out is a register.
  - On rd_ok, f_out <= mem[rd_ptr] and rd_ptr increments.
  - Otherwise f_out holds its value.
- FWFT mode (FWFT=1):
  - f_out = mem[rd_ptr] combinationally, so the head word is visible whenever f_empty == 0.
  - rd_ok only advances rd_ptr.
  - f_out is unspecified while f_empty == 1; the bench must not check it then.
- Errors:
  - wr_en & !wr_ok sets f_overflow; the data is dropped and no state changes.
  - rd_en & !rd_ok sets f_underflow; f_out holds in standard mode.
  - Both flags stay set until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Reset (rst = 0, asynchronous):
  - Pointers = 0, f_counter = 0, f_out = 0.
  - f_empty = 1, f_full = 0, f_almost_empty = 1, f_almost_full = 0 (AF_THRESH >= 1).
  - f_overflow = 0, f_underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately, without waiting for a clock edge.
  - Reset release is synchronous to the design.

## Timing
- Write latency:
  - A word written at edge N is counted in f_counter, and reflected in f_empty and the almost flags, immediately after edge N.
  - Standard mode: the earliest read is requested in cycle N+1, and the data appears on f_out after edge N+1.
  - FWFT mode: the data is on f_out after edge N.
- Read latency, standard mode: one cycle from rd_en sampled high to f_out valid.
- Full throughput: one push and one pop per cycle, sustained at any occupancy 1..DEPTH-1, and also at DEPTH.
- Flags lag the handshake by exactly one edge; there are no combinational paths from wr_en or rd_en to any flag.
- Error flags are visible after the edge that sampled the offending request.

## Test plan
- Reset, then push 1, 2, 3 and pop three times (standard mode) -> f_out reads 1, 2, 3, each one cycle after its rd_en; f_counter goes 0→3→0; f_empty returns to 1.
- Push 10, 20, …, 80 to fill the FIFO, then push 90 -> f_full = 1 and f_counter = 8; 90 is dropped; f_overflow = 1; draining yields 10…80; f_almost_full falls when f_counter drops to 5.
- With f_full = 1, push 99 and pop in the same cycle -> both are accepted; f_counter stays 8; 99 is read last after wrap-around.
- Pop on an empty FIFO while pushing 7 in the same cycle -> the read is rejected, f_underflow = 1, f_out holds, f_counter = 1; err_clr then clears f_underflow.
- FWFT=1: push 0x55 -> f_out = 0x55 right after the write edge, with no rd_en; pop then push 0xAA -> f_out = 0xAA.
- Drive rst low mid-stream with f_counter = 5 -> all outputs take their reset values asynchronously, before the next clk edge; a subsequent push and pop of 0x3C reads back 0x3C.
